pll_lock_reset_seq: RTL and testbench



---
 rtl/pll_lock_reset_seq.sv | 134 +++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pll_lock_reset_seq: turns the PLL lock indication into a qualified,       |
// | synchronous system reset, blanking the LED panel before reset on loss.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module pll_lock_reset_seq #(
   parameter int QUALIFY_CYCLES = 1024,
   parameter int HOLD_CYCLES    = 16,
   parameter int DRAIN_TIMEOUT  = 256,
   parameter int LOSS_CNT_W     = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  locked,
   input  logic                  blank_ack,
   output logic                  sys_reset,
   output logic                  blank_req,
   output logic                  ready,
   output logic [LOSS_CNT_W-1:0] loss_count,
   output logic [2:0]            state
);

   localparam logic [2:0] c_WAIT_LOCK = 3'd0;
   localparam logic [2:0] c_QUALIFY   = 3'd1;
   localparam logic [2:0] c_HOLD      = 3'd2;
   localparam logic [2:0] c_RUN       = 3'd3;
   localparam logic [2:0] c_DRAIN     = 3'd4;

   localparam int c_MAX_QH  = (QUALIFY_CYCLES > HOLD_CYCLES) ? QUALIFY_CYCLES : HOLD_CYCLES;
   localparam int c_MAX_CNT = (c_MAX_QH > DRAIN_TIMEOUT) ? c_MAX_QH : DRAIN_TIMEOUT;
   localparam int c_CNT_W   = (c_MAX_CNT > 1) ? $clog2(c_MAX_CNT) : 1;

   localparam logic [c_CNT_W-1:0] c_QUAL_LAST  = c_CNT_W'(QUALIFY_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(HOLD_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(DRAIN_TIMEOUT - 1);

   logic                  r_sync1;
   logic                  r_lk_s;
   logic [2:0]            r_state;
   logic [c_CNT_W-1:0]    r_cnt;
   logic                  r_sys_reset;
   logic                  r_blank_req;
   logic                  r_ready;
   logic [LOSS_CNT_W-1:0] r_loss_count;

   logic [2:0]            w_next_state;
   logic [c_CNT_W-1:0]    w_cnt_next;
   logic                  w_loss_inc;

   // One shared counter: each timed state starts it from zero on entry.
   always_comb begin
      w_next_state = r_state;
      w_cnt_next   = r_cnt + 1'b1;
      w_loss_inc   = 1'b0;
      case (r_state)
         c_WAIT_LOCK: begin
            w_cnt_next = '0;
            if (r_lk_s) begin
               w_next_state = c_QUALIFY;
            end
         end
         c_QUALIFY: begin
            if (!r_lk_s) begin
               w_next_state = c_WAIT_LOCK;
               w_cnt_next   = '0;
            end else if (r_cnt == c_QUAL_LAST) begin
               w_next_state = c_HOLD;
               w_cnt_next   = '0;
            end
         end
         c_HOLD: begin
            if (!r_lk_s) begin
               w_next_state = c_WAIT_LOCK;
               w_cnt_next   = '0;
            end else if (r_cnt == c_HOLD_LAST) begin
               w_next_state = c_RUN;
               w_cnt_next   = '0;
            end
         end
         c_RUN: begin
            w_cnt_next = '0;
            if (!r_lk_s) begin
               w_next_state = c_DRAIN;
               w_loss_inc   = 1'b1;
            end
         end
         c_DRAIN: begin
            // Returning lock is deliberately ignored until the drain completes.
            if (blank_ack || (r_cnt == c_DRAIN_LAST)) begin
               w_next_state = c_WAIT_LOCK;
               w_cnt_next   = '0;
            end
         end
         default: begin
            w_next_state = c_WAIT_LOCK;
            w_cnt_next   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1      <= 1'b0;
         r_lk_s       <= 1'b0;
         r_state      <= c_WAIT_LOCK;
         r_cnt        <= '0;
         r_sys_reset  <= 1'b1;
         r_blank_req  <= 1'b0;
         r_ready      <= 1'b0;
         r_loss_count <= '0;
      end else begin
         r_sync1     <= locked;
         r_lk_s      <= r_sync1;
         r_state     <= w_next_state;
         r_cnt       <= w_cnt_next;
         r_sys_reset <= !((w_next_state == c_RUN) || (w_next_state == c_DRAIN));
         r_blank_req <= (w_next_state == c_DRAIN);
         r_ready     <= (w_next_state == c_RUN);
         if (w_loss_inc && (r_loss_count != {LOSS_CNT_W{1'b1}})) begin
            r_loss_count <= r_loss_count + 1'b1;
         end
      end
   end

   assign sys_reset  = r_sys_reset;
   assign blank_req  = r_blank_req;
   assign ready      = r_ready;
   assign loss_count = r_loss_count;
   assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_reset_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pll_lock_reset_seq: scoreboard bench for pll_lock_reset_seq.           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pll_lock_reset_seq;

   localparam int Q  = 8;
   localparam int H  = 4;
   localparam int D  = 16;
   localparam int LW = 2;

   localparam int M_WAIT  = 0;
   localparam int M_QUAL  = 1;
   localparam int M_HOLD  = 2;
   localparam int M_RUN   = 3;
   localparam int M_DRAIN = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          locked;
   logic          blank_ack;
   logic          sys_reset;
   logic          blank_req;
   logic          ready;
   logic [LW-1:0] loss_count;
   logic [2:0]    state;

   typedef struct packed {
      logic          sr;
      logic          br;
      logic          rd;
      logic [LW-1:0] lc;
      logic [2:0]    st;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   m_s1, m_s2, m_mode, m_cyc, m_loss;

   pll_lock_reset_seq #(
      .QUALIFY_CYCLES (Q),
      .HOLD_CYCLES    (H),
      .DRAIN_TIMEOUT  (D),
      .LOSS_CNT_W     (LW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .locked     (locked),
      .blank_ack  (blank_ack),
      .sys_reset  (sys_reset),
      .blank_req  (blank_req),
      .ready      (ready),
      .loss_count (loss_count),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
   endtask

   function automatic exp_t model_out(input int mode, input int loss);
      exp_t e;
      e.sr = !((mode == M_RUN) || (mode == M_DRAIN));
      e.br = (mode == M_DRAIN);
      e.rd = (mode == M_RUN);
      e.lc = LW'(loss);
      e.st = 3'(mode);
      return e;
   endfunction

   // Reference model: mode plus "cycles spent in mode", stepped once per edge.
   initial begin
      int lk;
      m_s1 = 0; m_s2 = 0; m_mode = M_WAIT; m_cyc = 0; m_loss = 0;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_s1 = 0; m_s2 = 0; m_mode = M_WAIT; m_cyc = 0; m_loss = 0;
            exp_q.delete();
         end else begin
            lk   = m_s2;
            m_s2 = m_s1;
            m_s1 = int'(locked);
            case (m_mode)
               M_WAIT:  if (lk != 0) begin m_mode = M_QUAL; m_cyc = 1; end
               M_QUAL: begin
                  if (lk == 0)        begin m_mode = M_WAIT; m_cyc = 1; end
                  else if (m_cyc == Q) begin m_mode = M_HOLD; m_cyc = 1; end
                  else m_cyc++;
               end
               M_HOLD: begin
                  if (lk == 0)        begin m_mode = M_WAIT; m_cyc = 1; end
                  else if (m_cyc == H) begin m_mode = M_RUN; m_cyc = 1; end
                  else m_cyc++;
               end
               M_RUN: begin
                  if (lk == 0) begin
                     if (m_loss < (1 << LW) - 1) m_loss++;
                     m_mode = M_DRAIN; m_cyc = 1;
                  end
               end
               default: begin
                  if (blank_ack || (m_cyc == D)) begin m_mode = M_WAIT; m_cyc = 1; end
                  else m_cyc++;
               end
            endcase
         end
         exp_q.push_back(model_out(m_mode, m_loss));
      end
   end

   // Monitor: outputs are valid every cycle; compare on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            chk("mon_queue_empty", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("mon_sys_reset",  int'(sys_reset),  int'(e.sr));
            chk("mon_blank_req",  int'(blank_req),  int'(e.br));
            chk("mon_ready",      int'(ready),      int'(e.rd));
            chk("mon_loss_count", int'(loss_count), int'(e.lc));
            chk("mon_state",      int'(state),      int'(e.st));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("async_sys_reset",  int'(sys_reset),  1);
      chk("async_blank_req",  int'(blank_req),  0);
      chk("async_loss_count", int'(loss_count), 0);
      chk("async_state",      int'(state),      0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int n;
      int c;
      reset = 1'b1; locked = 1'b0; blank_ack = 1'b0;
      repeat (3) @(negedge clk);
      locked = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      n = 0;
      do begin @(negedge clk); n++; end while (sys_reset && n < 100);
      chk("release_latency", n, 15);
      chk("ready_at_release", int'(ready), 1);

      repeat (3) @(negedge clk);
      locked = 1'b0;
      n = 0;
      while (!blank_req && n < 20) begin @(negedge clk); n++; end
      chk("loss_to_blank_req", n, 3);
      repeat (3) @(negedge clk);
      blank_ack = 1'b1;
      @(negedge clk);
      chk("ack_sys_reset",  int'(sys_reset),  1);
      chk("ack_blank_req",  int'(blank_req),  0);
      chk("ack_state",      int'(state),      0);
      chk("ack_loss_count", int'(loss_count), 1);
      blank_ack = 1'b0;

      @(negedge clk);
      locked = 1'b1;
      repeat (5) @(negedge clk);
      locked = 1'b0;
      @(negedge clk);
      locked = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (sys_reset && n < 100);
      chk("glitch_restart_latency", n, 15);

      repeat (3) @(negedge clk);
      locked = 1'b0;
      n = 0;
      while (!blank_req && n < 20) begin @(negedge clk); n++; end
      c = 0;
      while (blank_req && c < 50) begin c++; @(negedge clk); end
      chk("drain_timeout_len", c, 16);
      chk("timeout_sys_reset", int'(sys_reset), 1);

      locked = 1'b1;
      repeat (20) @(negedge clk);
      locked = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_reset_drain_state", int'(state), M_DRAIN);
      do_reset();

      locked = 1'b1;
      repeat (12) @(negedge clk);
      chk("pre_reset_hold_state", int'(state), M_HOLD);
      do_reset();

      locked = 1'b1;
      for (int i = 0; i < 5; i++) begin
         repeat (20) @(negedge clk);
         locked = 1'b0;
         blank_ack = 1'b1;
         repeat (4) @(negedge clk);
         blank_ack = 1'b0;
         locked = 1'b1;
      end
      chk("loss_count_saturated", int'(loss_count), 3);

      for (int ep = 0; ep < 60; ep++) begin
         locked = 1'b1;
         n = int'($urandom_range(3, 35));
         repeat (n) begin @(negedge clk); blank_ack = ($urandom_range(0, 7) == 0); end
         locked = 1'b0;
         n = int'($urandom_range(1, 24));
         repeat (n) begin @(negedge clk); blank_ack = ($urandom_range(0, 7) == 0); end
      end
      blank_ack = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
